// File: rtl/img_proc_pkg.sv
// Shared definitions for the image processing unit: FSM encoding and
// default image geometry.
package img_proc_pkg;

    localparam int unsigned IMAGESIZE_DEF = 512;
    localparam int unsigned PIXELSIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/line_credit_counter.sv
// Line-buffer credit counter: load to full, +1 per returned line, -1 per
// consumed line; a return at full credit is flagged instead of counted.
module line_credit_counter #(
    parameter int unsigned MAX_CREDIT = 4,
    parameter int unsigned W          = $clog2(MAX_CREDIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);

    assign overflow = inc && !dec && !load && (count == W'(MAX_CREDIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(MAX_CREDIT);
        end else if (inc && !dec && !overflow) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame sequencer: gates the host pixel stream by line-buffer credits,
// tracks row/column position and counts output transfers to end the frame.
module img_frame_sequencer
    import img_proc_pkg::*;
#(
    parameter int unsigned IMAGESIZE     = IMAGESIZE_DEF,
    parameter int unsigned PIXELSIZE     = PIXELSIZE_DEF,
    parameter int unsigned PRELOAD_LINES = 4,
    parameter int unsigned OUT_LINES     = IMAGESIZE - 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 s_valid,
    input  logic [PIXELSIZE-1:0]                 s_data,
    output logic                                 s_ready,
    output logic                                 pixel_valid,
    output logic [PIXELSIZE-1:0]                 pixel_input,
    input  logic                                 pixel_request,
    input  logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [$clog2(IMAGESIZE)-1:0]         row_cnt,
    output logic [$clog2(IMAGESIZE)-1:0]         col_cnt,
    output logic [$clog2(PRELOAD_LINES+1)-1:0]   credit,
    output logic                                 err_credit
);

    localparam int unsigned CW        = $clog2(IMAGESIZE);
    localparam int unsigned OUT_TOTAL = OUT_LINES * IMAGESIZE;
    localparam int unsigned OW        = $clog2(OUT_TOTAL + 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic            accept;
    logic            line_end;
    logic            last_pixel;
    logic            out_xfer;
    logic            out_hit;
    logic [OW-1:0]   out_cnt;
    logic [OW-1:0]   out_cnt_nxt;
    logic            credit_clr;
    logic            credit_load;
    logic            credit_inc;
    logic            credit_ovf;

    assign s_ready     = (state == FEED) && (credit != '0);
    assign accept      = s_valid && s_ready;
    assign line_end    = accept && (col_cnt == CW'(IMAGESIZE - 1));
    assign last_pixel  = line_end && (row_cnt == CW'(IMAGESIZE - 1));

    // Output counter saturates at the frame total so late transfers are ignored.
    assign out_xfer    = out_valid && out_ready && ((state == FEED) || (state == DRAIN))
                         && (out_cnt != OW'(OUT_TOTAL));
    assign out_cnt_nxt = out_cnt + OW'(out_xfer);
    assign out_hit     = (out_cnt_nxt == OW'(OUT_TOTAL));

    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

    // Abort shares the counter's clear so it outranks a same-cycle start.
    assign credit_clr  = rst || abort;
    assign credit_load = (state == IDLE) && start;
    assign credit_inc  = pixel_request && (state != IDLE);

    line_credit_counter #(
        .MAX_CREDIT (PRELOAD_LINES)
    ) u_credit (
        .clk      (clk),
        .rst      (credit_clr),
        .load     (credit_load),
        .inc      (credit_inc),
        .dec      (line_end),
        .count    (credit),
        .overflow (credit_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FEED;
                FEED:    if (last_pixel) state_nxt = out_hit ? DONE : DRAIN;
                DRAIN:   if (out_hit) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel_input <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            out_cnt     <= '0;
            err_credit  <= 1'b0;
        end else if (abort) begin
            pixel_valid <= 1'b0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            out_cnt     <= '0;
        end else begin
            pixel_valid <= accept;
            if (accept) begin
                pixel_input <= s_data;
            end
            if (credit_load) begin
                row_cnt    <= '0;
                col_cnt    <= '0;
                out_cnt    <= '0;
                err_credit <= 1'b0;
            end else begin
                if (line_end) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == CW'(IMAGESIZE - 1)) ? '0 : row_cnt + CW'(1);
                end else if (accept) begin
                    col_cnt <= col_cnt + CW'(1);
                end
                out_cnt <= out_cnt_nxt;
                if (credit_ovf) begin
                    err_credit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Scoreboard bench for img_frame_sequencer against a frame-level model
// (pixel count, credit balance, output count) with randomized traffic.
module tb_img_frame_sequencer;

    localparam int IMG   = 8;
    localparam int PRE   = 4;
    localparam int OUTL  = 6;
    localparam int TOTAL = OUTL * IMG;

    localparam int P_IDLE  = 0;
    localparam int P_FEED  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       pixel_valid;
    logic [7:0] pixel_input;
    logic       pixel_request;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_done;
    logic [2:0] row_cnt;
    logic [2:0] col_cnt;
    logic [2:0] credit;
    logic       err_credit;

    int checks = 0;
    int errors = 0;
    int pv_seen = 0;
    int done_cnt = 0;

    // Frame-level reference: how many pixels taken, credits held, outputs seen.
    int m_phase, m_acc, m_outs, m_credit;
    bit m_err;
    logic [7:0] exp_q[$];

    img_frame_sequencer #(
        .IMAGESIZE     (IMG),
        .PIXELSIZE     (8),
        .PRELOAD_LINES (PRE),
        .OUT_LINES     (OUTL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .pixel_valid   (pixel_valid),
        .pixel_input   (pixel_input),
        .pixel_request (pixel_request),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .row_cnt       (row_cnt),
        .col_cnt       (col_cnt),
        .credit        (credit),
        .err_credit    (err_credit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_status();
        chk("s_ready", 32'(s_ready), 32'(m_phase == P_FEED && m_credit > 0));
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
        chk("row_cnt", 32'(row_cnt), 32'((m_acc / IMG) % IMG));
        chk("col_cnt", 32'(col_cnt), 32'(m_acc % IMG));
        chk("credit", 32'(credit), 32'(m_credit));
        chk("err_credit", 32'(err_credit), 32'(m_err));
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic model_update(input logic sv, input logic pr, input logic ov,
                                input logic orr, input logic ab, input logic st,
                                input logic [7:0] d);
        bit acc;
        bit line_end;
        if (ab) begin
            m_phase = P_IDLE; m_acc = 0; m_outs = 0; m_credit = 0;
        end else if (m_phase == P_IDLE) begin
            if (st) begin
                m_phase = P_FEED; m_acc = 0; m_outs = 0; m_credit = PRE; m_err = 0;
            end
        end else begin
            acc = (m_phase == P_FEED) && sv && (m_credit > 0);
            line_end = acc && (m_acc % IMG == IMG - 1);
            if (acc) begin
                exp_q.push_back(d);
                m_acc++;
            end
            if (pr && !line_end && m_credit == PRE) m_err = 1;
            else m_credit = m_credit + int'(pr) - int'(line_end);
            if (ov && orr && (m_phase == P_FEED || m_phase == P_DRAIN) && m_outs < TOTAL)
                m_outs++;
            if (m_phase == P_DONE) m_phase = P_IDLE;
            else if (m_phase == P_FEED && acc && m_acc == IMG * IMG)
                m_phase = (m_outs == TOTAL) ? P_DONE : P_DRAIN;
            else if (m_phase == P_DRAIN && m_outs == TOTAL) m_phase = P_DONE;
        end
    endtask

    task automatic step(input logic sv, input logic pr, input logic ov,
                        input logic orr, input logic ab, input logic st);
        logic [7:0] d;
        @(negedge clk);
        check_status();
        d = 8'($urandom);
        s_valid = sv; s_data = d; pixel_request = pr;
        out_valid = ov; out_ready = orr; abort = ab; start = st;
        model_update(sv, pr, ov, orr, ab, st, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        pixel_request = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
        m_phase = P_IDLE; m_acc = 0; m_outs = 0; m_credit = 0; m_err = 0;
        repeat (2) begin
            @(negedge clk);
            check_status();
            chk("rst_pixel_valid", 32'(pixel_valid), 0);
            chk("rst_pixel_input", 32'(pixel_input), 0);
        end
        rst = 1'b0;
    endtask

    task automatic run_frame(input int limit, input int sv_pct, input int pr_pct,
                             input int out_pct, input bit to_drain);
        int n;
        logic sv, pr, ov, orr, st;
        n = 0;
        while (n < limit && (to_drain ? (m_phase != P_DRAIN) : (m_phase != P_IDLE))) begin
            sv  = ($urandom_range(99) < sv_pct);
            pr  = (m_credit < PRE) && ($urandom_range(99) < pr_pct);
            ov  = ($urandom_range(99) < out_pct);
            orr = ($urandom_range(99) < 80);
            st  = ($urandom_range(99) < 3);
            step(sv, pr, ov, orr, 1'b0, st);
            n++;
        end
        chk("frame_progress_timeout", 32'(n < limit), 1);
    endtask

    // Monitor: every forwarded pixel must match the next accepted host pixel.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (pixel_valid === 1'b1) begin
                pv_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected actual=%0h expected=none", pixel_input);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_data", 32'(pixel_input), 32'(e));
                end
            end
        end
    end

    initial begin
        int n;
        int base;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        pixel_request = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
        do_reset();

        // Frame A: credit stall, credit returns, drain with 48 transfers.
        pv_seen = 0; done_cnt = 0;
        step(0, 0, 0, 0, 0, 1);
        repeat (40) step(1, 0, 0, 0, 0, 0);
        chk("stall_pixels", 32'(pv_seen), 32);
        chk("stall_s_ready", 32'(s_ready), 0);
        chk("stall_credit", 32'(credit), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
        end
        n = 0;
        while (m_acc < IMG * IMG && n < 200) begin
            step(1, 0, 0, 0, 0, 0);
            n++;
        end
        chk("feed_timeout", 32'(n < 200), 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("all_pixels", 32'(pv_seen), 64);
        chk("drain_s_ready", 32'(s_ready), 0);
        chk("drain_busy", 32'(busy), 1);
        run_frame(500, 0, 0, 70, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("frameA_done_pulses", 32'(done_cnt), 1);
        chk("frameA_busy", 32'(busy), 0);

        // Frame B: credit overflow, coincident consume/return, random finish.
        done_cnt = 0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("ovf_credit", 32'(credit), 4);
        chk("ovf_err", 32'(err_credit), 1);
        n = 0;
        while (m_acc < 31 && n < 100) begin
            step(1, 0, 0, 0, 0, 0);
            n++;
        end
        step(0, 0, 0, 0, 0, 0);
        chk("coinc_col", 32'(col_cnt), 7);
        chk("coinc_credit_before", 32'(credit), 1);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("coinc_credit_after", 32'(credit), 1);
        chk("coinc_s_ready", 32'(s_ready), 1);
        run_frame(1500, 40, 25, 90, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("frameB_done_pulses", 32'(done_cnt), 1);
        chk("frameB_err_held", 32'(err_credit), 1);

        // Frame C: abort after 20 pixels.
        done_cnt = 0;
        base = pv_seen;
        step(0, 0, 0, 0, 0, 1);
        n = 0;
        while (m_acc < 20 && n < 100) begin
            step(1, 0, 0, 0, 0, 0);
            n++;
        end
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_row", 32'(row_cnt), 0);
        chk("abort_col", 32'(col_cnt), 0);
        chk("abort_pixels", 32'(pv_seen - base), 20);
        chk("abort_no_done", 32'(done_cnt), 0);

        // Frame D: reset while draining, then a clean full frame.
        done_cnt = 0;
        step(0, 0, 0, 0, 0, 1);
        run_frame(1500, 70, 25, 0, 1'b1);
        repeat (5) step(0, 0, 1, 1, 0, 0);
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_no_done", 32'(done_cnt), 0);
        step(0, 0, 0, 0, 0, 1);
        run_frame(1500, 70, 25, 70, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("frameD_done_pulses", 32'(done_cnt), 1);
        chk("frameD_busy", 32'(busy), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_frame_sequencer.md
IMG_FRAME_SEQUENCER -- requirements
Module: img_frame_sequencer

Interface
REQ-001 The module SHALL have parameter IMAGESIZE, default 512: pixels per line and lines per frame.
REQ-002 The module SHALL have parameter PIXELSIZE, default 8: pixel width in bits.
REQ-003 The module SHALL have parameter PRELOAD_LINES, default 4: line credits granted at frame start, matching the line-buffer count.
REQ-004 The module SHALL have parameter OUT_LINES, default IMAGESIZE-2: output lines expected per frame; OUT_TOTAL = OUT_LINES*IMAGESIZE.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port start, input, 1 bit: frame start pulse; honoured only in IDLE.
REQ-008 The module SHALL have port abort, input, 1 bit: cancels the frame from any state.
REQ-009 The module SHALL have ports s_valid (input, 1), s_data (input, PIXELSIZE) and s_ready (output, 1): host pixel stream with valid/ready handshake.
REQ-010 The module SHALL have ports pixel_valid (output, 1) and pixel_input (output, PIXELSIZE): pixel feed to the processing unit.
REQ-011 The module SHALL have port pixel_request, input, 1 bit: one-cycle pulse from the line buffers meaning one line was consumed and one credit is returned.
REQ-012 The module SHALL have ports out_valid (input, 1) and out_ready (input, 1): monitor of the output FIFO handshake.
REQ-013 The module SHALL have status outputs: busy (1); frame_done (1, pulse); row_cnt and col_cnt (clog2(IMAGESIZE) each); credit (clog2(PRELOAD_LINES+1)); err_credit (1, sticky).

Function
REQ-014 The module SHALL implement FSM states IDLE, FEED, DRAIN and DONE.
REQ-015 IDLE -> FEED SHALL occur on start; entry SHALL set credit=PRELOAD_LINES and clear row_cnt, col_cnt and the output counter.
REQ-016 s_ready SHALL be combinational: (state==FEED) && credit!=0.
REQ-017 On each s_valid&&s_ready, the module SHALL set pixel_valid=1 and pixel_input=s_data on the next cycle (1-cycle latency); pixel_valid SHALL be 0 otherwise.
REQ-018 col_cnt SHALL increment per accepted pixel and wrap at IMAGESIZE-1 to 0 with row_cnt++; each wrap SHALL consume one credit.
REQ-019 A pixel_request pulse SHALL add one credit; a simultaneous line-end consume and pixel_request SHALL leave credit unchanged.
REQ-020 A pixel_request arriving at credit==PRELOAD_LINES with no consume SHALL hold credit and set err_credit, cleared only by reset or start.
REQ-021 Acceptance of the last pixel (row=col=IMAGESIZE-1) SHALL take FEED -> DRAIN; s_ready SHALL be 0 in DRAIN.
REQ-022 The output counter SHALL increment on out_valid&&out_ready in FEED and DRAIN.
REQ-023 DRAIN -> DONE SHALL occur the cycle the counter reaches OUT_TOTAL; if OUT_TOTAL is reached while in FEED, DONE SHALL follow acceptance of the last input pixel.
REQ-024 DONE SHALL last one cycle, assert frame_done=1, then go to IDLE; further out transfers SHALL be ignored.
REQ-025 busy SHALL be 1 in FEED, DRAIN and DONE.
REQ-026 abort SHALL force IDLE on the next edge from any state, clear all counters and suppress frame_done; abort SHALL have priority over start and over all other transitions.
REQ-027 start outside IDLE SHALL be ignored.

Reset
REQ-028 While rst=1, state SHALL be IDLE and s_ready, pixel_valid, busy, frame_done and err_credit SHALL be 0; pixel_input, row_cnt, col_cnt, credit and the output counter SHALL be 0.
REQ-029 rst SHALL have priority over abort and start; a reset mid-frame SHALL discard all progress with no frame_done.

Structure
REQ-030 The FSM state encoding and the IMAGESIZE and PIXELSIZE defaults SHALL reside in a shared package, img_proc_pkg, used by the processing-unit top.
REQ-031 The credit counter SHALL be a sub-module, line_credit_counter (inputs: load, inc, dec; outputs: count, overflow).

Verification (IMAGESIZE=8, PRELOAD_LINES=4, OUT_LINES=6)
REQ-032 The bench SHALL cover: reset, then start with s_valid held high and no pixel_request -> exactly 32 pixels pass, then s_ready=0 and credit=0.
REQ-033 The bench SHALL cover: four pixel_request pulses after that stall -> the remaining 32 pixels pass, then DRAIN; 48 out transfers -> frame_done pulses once, then busy=0.
REQ-034 The bench SHALL cover: pixel_request coincident with the 8th pixel of a line at credit=1 -> credit stays 1 and streaming continues.
REQ-035 The bench SHALL cover: pixel_request at credit=4 in FEED before any line ends -> credit=4 and err_credit=1.
REQ-036 The bench SHALL cover: abort at pixel 20 -> next cycle IDLE with row_cnt=col_cnt=0, and no frame_done.
REQ-037 The bench SHALL cover: rst asserted in DRAIN -> all outputs 0 next cycle; a new start then runs a full frame correctly.
